// File: rtl/alu_modexp_seq.sv
// ALU opcode symbols shared with the combinational ALU, followed by the modexp sequencer.
// Optional build macro: MODEXP_SKIP_LZ_EN (skip leading zero exponent bits).
package alu_defs;
  localparam logic [2:0] MOV_      = 3'd0;
  localparam logic [2:0] ARITH_ADD = 3'd1;
  localparam logic [2:0] ARITH_SUB = 3'd2;
  localparam logic [2:0] ARITH_MUL = 3'd3;
endpackage

// Computes base^exp mod m by square-and-multiply, reducing through repeated ALU subtraction.
// Latency: data dependent, one ALU step per cycle; operand errors finish in one cycle.
// No backpressure: start_i is taken only in IDLE, ignored while busy_o or done_o is high.
module alu_modexp_seq
  import alu_defs::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] base_i,
  input  logic [N-1:0] exp_i,
  input  logic [N-1:0] mod_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [N-1:0] result_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [2:0]   alu_opcode_o,
  input  logic [N-1:0] alu_result_i,
  input  logic [1:0]   alu_flags_i
);

  localparam int KW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);
  // Keeps every square/product below 2^(N-2) so the result MSB is a valid sign.
  localparam logic [N-1:0] MOD_LIMIT = ONE << (N/2 - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RED_B, S_RED_S, S_RED_M, S_SQ, S_MULB, S_NEXT, S_SKIP, S_DONE
  } state_t;

  typedef struct packed {
    logic [2:0]   opcode;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } alu_cmd_t;

  state_t          state, state_nx;
  alu_cmd_t        alu_cmd;
  logic [N-1:0]    base_r, exp_r, mod_r, acc, t;
  logic [KW-1:0]   k;
  logic            op_bad;
  logic            sub_neg;
  logic            unused_zero_flag;

  assign op_bad  = (mod_i[N-1:1] == '0) || (mod_i >= MOD_LIMIT) || base_i[N-1];
  assign sub_neg = alu_flags_i[1];
  // The sign alone ends a reduction; a zero result just takes one more step.
  assign unused_zero_flag = alu_flags_i[0];

  assign alu_opcode_o = alu_cmd.opcode;
  assign alu_a_o      = alu_cmd.a;
  assign alu_b_o      = alu_cmd.b;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_i) state_nx = op_bad ? S_DONE : S_RED_B;
`ifdef MODEXP_SKIP_LZ_EN
      S_RED_B: if (sub_neg) state_nx = S_SKIP;
      S_SKIP: begin
        if (exp_r == '0)   state_nx = S_DONE;
        else if (exp_r[k]) state_nx = S_MULB;
      end
`else
      S_RED_B: if (sub_neg) state_nx = S_SQ;
`endif
      S_RED_S: if (sub_neg) state_nx = exp_r[k] ? S_MULB : S_NEXT;
      S_RED_M: if (sub_neg) state_nx = S_NEXT;
      S_SQ:    state_nx = S_RED_S;
      S_MULB:  state_nx = S_RED_M;
      S_NEXT:  state_nx = (k == '0) ? S_DONE : S_SQ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    alu_cmd = '{opcode: MOV_, a: '0, b: '0};
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state)
      S_IDLE: ;
      S_RED_B, S_RED_S, S_RED_M: begin
        alu_cmd = '{opcode: ARITH_SUB, a: t, b: mod_r};
        busy_o  = 1'b1;
      end
      S_SQ: begin
        alu_cmd = '{opcode: ARITH_MUL, a: acc, b: acc};
        busy_o  = 1'b1;
      end
      S_MULB: begin
        alu_cmd = '{opcode: ARITH_MUL, a: acc, b: base_r};
        busy_o  = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= '0;
      exp_r    <= '0;
      mod_r    <= '0;
      acc      <= '0;
      t        <= '0;
      k        <= '0;
      err_o    <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            base_r   <= base_i;
            exp_r    <= exp_i;
            mod_r    <= mod_i;
            t        <= base_i;
            acc      <= ONE;
            k        <= KW'(N - 1);
            err_o    <= op_bad;
            result_o <= '0;
          end
        end
        S_RED_B: begin
          if (sub_neg) base_r <= t;
          else         t      <= alu_result_i;
        end
        S_RED_S, S_RED_M: begin
          if (sub_neg) acc <= t;
          else         t   <= alu_result_i;
        end
        S_SQ, S_MULB: t <= alu_result_i;
        S_NEXT: begin
          if (k == '0) result_o <= acc;
          else         k        <= k - KW'(1);
        end
`ifdef MODEXP_SKIP_LZ_EN
        S_SKIP: begin
          // acc is still 1 here, so an all-zero exponent finishes with result 1.
          if (exp_r == '0)    result_o <= acc;
          else if (!exp_r[k]) k        <= k - KW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
